// File: rtl/tru_serial_ctrl.sv
// Bit-serial N-bit subtractor sequencer.
// Captures a, b and bin on an accepted start, then steps one full-subtractor
// cell LSB-first for N cycles. Difference bits are shifted into the result
// register from the top, and the final borrow is latched into bout.
module tru_serial_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         bout
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [N-1:0]   res;
  logic           brw;
  logic           bout_q;
  logic           last_bit;

  // One-bit full-subtractor cell working on the operand LSBs and the borrow flop.
  logic cell_a, cell_b, cell_d, cell_bo;
  assign cell_a  = a_sh[0];
  assign cell_b  = b_sh[0];
  assign cell_d  = cell_a ^ cell_b ^ brw;
  assign cell_bo = (~cell_a & cell_b) | ((~cell_a | cell_b) & brw);

  assign last_bit = (cnt == CW'(N - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status decode; start only matters in IDLE.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand load on accept, then one bit per cycle; result and bout untouched on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      brw    <= 1'b0;
      res    <= '0;
      bout_q <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_sh <= a;
        b_sh <= b;
        brw  <= bin;
        cnt  <= '0;
      end else if (state == RUN) begin
        res  <= {cell_d, res[N-1:1]};
        a_sh <= {1'b0, a_sh[N-1:1]};
        b_sh <= {1'b0, b_sh[N-1:1]};
        brw  <= cell_bo;
        if (last_bit) bout_q <= cell_bo;
        else          cnt    <= cnt + CW'(1);
      end
    end
  end

  assign d    = res;
  assign bout = bout_q;

endmodule

// File: tb/tb_tru_serial_ctrl.sv
// Self-checking bench for tru_serial_ctrl (N=8): directed and random
// subtractions checked against an arithmetic reference, plus start-ignore,
// mid-run reset and back-to-back throughput scenarios.
module tb_tru_serial_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] d;
  logic         bout;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] prev_d;
  logic         prev_bout;

  int cycles, ndone, last, extra;

  tru_serial_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, independent of any bit-level view.
  function automatic logic [N:0] ref_sub(input logic [N-1:0] av, input logic [N-1:0] bv,
                                         input logic bi);
    int diff;
    logic [N-1:0] rd;
    logic rb;
    diff = int'(av) - int'(bv) - int'(bi);
    rd   = N'(diff);
    rb   = (int'(av) < int'(bv) + int'(bi));
    return {rb, rd};
  endfunction

  // One full operation; poke=1 fires a spurious start with new operands mid-run.
  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi,
                        input bit poke);
    logic [N:0] exp_r;
    int cyc, busy_cnt, ext;
    exp_r = ref_sub(av, bv, bi);
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~av; b = ~bv; bin = ~bi;
    check("hold_d_on_load", 32'(d), 32'(prev_d));
    check("hold_bout_on_load", 32'(bout), 32'(prev_bout));
    cyc = 1;
    busy_cnt = 0;
    while (!done && cyc < 4 * N) begin
      if (busy) busy_cnt++;
      if (poke && cyc == 3) begin
        start = 1'b1; a = '1; b = '0; bin = 1'b0;
      end else if (poke && cyc == 4) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("busy_low_at_done", 32'(busy), 32'd0);
    check("latency", 32'(cyc), 32'(N + 1));
    check("busy_cycles", 32'(busy_cnt), 32'(N));
    check("d", 32'(d), 32'(exp_r[N-1:0]));
    check("bout", 32'(bout), 32'(exp_r[N]));
    prev_d    = exp_r[N-1:0];
    prev_bout = exp_r[N];
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);
    check("d_held", 32'(d), 32'(exp_r[N-1:0]));
    if (poke) begin
      ext = 0;
      repeat (N + 4) begin
        if (done) ext++;
        @(posedge clk); #1;
      end
      check("single_done", 32'(ext), 32'd0);
      check("d_after_poke", 32'(d), 32'(exp_r[N-1:0]));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    prev_d = '0; prev_bout = 1'b0;
    #1;
    // ---- reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;

    // ---- directed cases
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 1'b0, 1'b0);
    run_op(8'h10, 8'h0F, 1'b1, 1'b0);
    run_op(8'h33, 8'h33, 1'b1, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op(8'hFF, 8'h00, 1'b0, 1'b0);

    // ---- spurious start during RUN is ignored
    run_op(8'h21, 8'h43, 1'b0, 1'b1);

    // ---- asynchronous reset mid-run
    @(negedge clk);
    a = 8'hC3; b = 8'h15; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_d", 32'(d), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    prev_d = '0; prev_bout = 1'b0;
    extra = 0;
    repeat (N + 3) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("no_done_after_abort", 32'(extra), 32'd0);
    run_op(8'h80, 8'h01, 1'b0, 1'b0);

    // ---- random operands
    repeat (12) begin
      run_op(N'($urandom), N'($urandom), 1'($urandom), 1'b0);
    end

    // ---- start held high: back-to-back operations
    @(negedge clk);
    a = 8'h05; b = 8'h07; bin = 1'b0; start = 1'b1;
    cycles = 0; ndone = 0; last = -1;
    while (ndone < 3 && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (done) begin
        ndone++;
        check("b2b_d", 32'(d), 32'hFE);
        check("b2b_bout", 32'(bout), 32'd1);
        if (last >= 0) check("b2b_spacing", 32'(cycles - last), 32'(N + 2));
        last = cycles;
        if (ndone == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(ndone), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
